// File: rtl/tdl_pkg.sv
// Shared types for the tap delay line: stride encoding, fill state and stride decode.
package tdl_pkg;

  typedef enum logic [1:0] {
    STRIDE_1    = 2'd0,
    STRIDE_2    = 2'd1,
    STRIDE_4    = 2'd2,
    STRIDE_RSVD = 2'd3
  } tdl_stride_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } tdl_state_e;

  // The reserved code decodes to 1; callers must qualify it separately.
  function automatic int unsigned stride_decode(tdl_stride_e sel);
    case (sel)
      STRIDE_2: return 2;
      STRIDE_4: return 4;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/tdl_fill_ctrl.sv
// Fill tracking for the tap delay line: EMPTY/FILL/FULL state machine, saturating
// fill counter, registered stride with implicit flush on change, sticky stride error.
module tdl_fill_ctrl
  import tdl_pkg::*;
#(
  parameter int unsigned TAPS       = 39,
  parameter int unsigned MAX_STRIDE = 4,
  parameter int unsigned CNT_W      = $clog2(MAX_STRIDE * TAPS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic             flush_i,
  input  logic [1:0]       stride_sel_i,
  output tdl_stride_e      stride_o,
  output logic             clear_o,
  output logic             accept_o,
  output logic             out_valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] fill_count_o,
  output logic             stride_err_o,
  output tdl_state_e       state_o
);

  tdl_state_e       state_q, state_d;
  tdl_stride_e      stride_q, stride_d, sel;
  logic [CNT_W-1:0] count_q, count_d, target;
  logic             err_q, err_d;
  logic             ov_q, ov_d;
  logic             sel_legal, sel_change, stride_change, clear, accept;

  // Illegal stride requests only raise the error; they never disturb the line.
  always_comb begin
    sel           = tdl_stride_e'(stride_sel_i);
    sel_legal     = (sel != STRIDE_RSVD) && (stride_decode(sel) <= MAX_STRIDE);
    sel_change    = (sel != stride_q);
    stride_change = sel_change && sel_legal;
    clear         = flush_i || stride_change;
    accept        = in_valid_i && !clear;
    target        = CNT_W'(TAPS * stride_decode(stride_q));
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    stride_d = stride_q;
    err_d    = err_q || (sel_change && !sel_legal);
    ov_d     = 1'b0;
    if (stride_change) stride_d = sel;
    if (clear) begin
      state_d = EMPTY;
      count_d = '0;
    end else if (accept) begin
      case (state_q)
        EMPTY, FILL: begin
          count_d = count_q + CNT_W'(1);
          state_d = (count_d == target) ? FULL : FILL;
        end
        default: state_d = FULL;
      endcase
      ov_d = (state_d == FULL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      stride_q <= STRIDE_1;
      err_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      stride_q <= stride_d;
      err_q    <= err_d;
      ov_q     <= ov_d;
    end
  end

  assign stride_o     = stride_q;
  assign clear_o      = clear;
  assign accept_o     = accept;
  assign out_valid_o  = ov_q;
  assign full_o       = (state_q == FULL);
  assign fill_count_o = count_q;
  assign stride_err_o = err_q;
  assign state_o      = state_q;

endmodule

// File: rtl/tap_delay_line.sv
// Strided tap delay line feeding the SC FIR multiplier bank.
// Optional build macro TDL_OUT_REG_EN adds an output register on taps/out_valid.
module tap_delay_line
  import tdl_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TAPS       = 39,
  parameter int unsigned MAX_STRIDE = 4
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 in_valid,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic [1:0]                           stride_sel,
  input  logic                                 flush,
  output logic [DATA_W-1:0]                    taps [TAPS-1:0],
  output logic                                 out_valid,
  output logic                                 full,
  output logic [$clog2(MAX_STRIDE*TAPS+1)-1:0] fill_count,
  output logic                                 stride_err,
  output tdl_state_e                           dbg_state
);

  localparam int DEPTH = int'(MAX_STRIDE * TAPS);
  localparam int unsigned CNT_W = $clog2(MAX_STRIDE * TAPS + 1);

  // in_valid has no backpressure: every in_valid cycle without a clear is accepted,
  // and out_valid is a single-cycle pulse with no ready.
  tdl_stride_e       stride;
  logic              clear, accept, ov_int;
  logic [DATA_W-1:0] storage_q [DEPTH-1:0];
  logic [DATA_W-1:0] taps_c    [TAPS-1:0];

  tdl_fill_ctrl #(
    .TAPS       (TAPS),
    .MAX_STRIDE (MAX_STRIDE),
    .CNT_W      (CNT_W)
  ) u_ctrl (
    .clk_i        (clock),
    .rst_ni       (reset_n),
    .in_valid_i   (in_valid),
    .flush_i      (flush),
    .stride_sel_i (stride_sel),
    .stride_o     (stride),
    .clear_o      (clear),
    .accept_o     (accept),
    .out_valid_o  (ov_int),
    .full_o       (full),
    .fill_count_o (fill_count),
    .stride_err_o (stride_err),
    .state_o      (dbg_state)
  );

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < DEPTH; i++) storage_q[i] <= '0;
    end else if (accept) begin
      storage_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) storage_q[i] <= storage_q[i-1];
    end
  end

  // Tap k sits (k+1)*stride samples back, i.e. storage[(k+1)*stride - 1].
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    if (MAX_STRIDE >= 4) begin : g_s4
      assign taps_c[k] = (stride == STRIDE_4) ? storage_q[4*k+3] :
                         (stride == STRIDE_2) ? storage_q[2*k+1] : storage_q[k];
    end else if (MAX_STRIDE >= 2) begin : g_s2
      assign taps_c[k] = (stride == STRIDE_2) ? storage_q[2*k+1] : storage_q[k];
    end else begin : g_s1
      assign taps_c[k] = storage_q[k];
    end
  end

`ifdef TDL_OUT_REG_EN
  logic [DATA_W-1:0] taps_q [TAPS-1:0];
  logic              out_valid_q;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < int'(TAPS); k++) taps_q[k] <= '0;
    end else begin
      out_valid_q <= ov_int;
      if (ov_int) taps_q <= taps_c;
    end
  end

  assign taps      = taps_q;
  assign out_valid = out_valid_q;
`else
  assign taps      = taps_c;
  assign out_valid = ov_int;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line (TAPS=4): history-queue reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_tap_delay_line;
  import tdl_pkg::*;

  localparam int TAPS  = 4;
  localparam int DW    = 8;
  localparam int MS    = 4;
  localparam int DEPTH = TAPS * MS;
`ifdef TDL_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          reset_n, in_valid, flush;
  logic [DW-1:0] in_data;
  logic [1:0]    stride_sel;
  logic [DW-1:0] taps [TAPS-1:0];
  logic          out_valid, full, stride_err;
  logic [4:0]    fill_count;
  tdl_state_e    dbg_state;

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;
  bit sb_en  = 1'b0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  tap_delay_line #(.DATA_W(DW), .TAPS(TAPS), .MAX_STRIDE(MS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .stride_sel (stride_sel),
    .flush      (flush),
    .taps       (taps),
    .out_valid  (out_valid),
    .full       (full),
    .fill_count (fill_count),
    .stride_err (stride_err),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[i] is the sample accepted i samples ago since the last clear.
  logic [DW-1:0] hist[$];
  int            sel_m = 0;
  bit            err_m = 1'b0, ov_m = 1'b0, ovr_m = 1'b0;
  logic [DW-1:0] win_m [TAPS];

  function automatic logic [DW-1:0] comb_tap(input int k);
    int idx;
    idx = (k + 1) * (1 << sel_m) - 1;
    if (idx < hist.size()) return hist[idx];
    return '0;
  endfunction

  always @(posedge clock) begin : model
    int s;
    bit legal, chg, clr, acc;
    if (!reset_n) begin
      hist.delete();
      sel_m = 0; err_m = 1'b0; ov_m = 1'b0; ovr_m = 1'b0;
      for (int k = 0; k < TAPS; k++) win_m[k] = '0;
    end else begin
      s     = int'(stride_sel);
      legal = (s != 3) && ((1 << s) <= MS);
      chg   = (s != sel_m);
      clr   = flush || (chg && legal);
      if (chg && !legal) err_m = 1'b1;
      if (clr) begin
        ovr_m = 1'b0;
        for (int k = 0; k < TAPS; k++) win_m[k] = '0;
      end else begin
        ovr_m = ov_m;
        if (ov_m) for (int k = 0; k < TAPS; k++) win_m[k] = comb_tap(k);
      end
      if (chg && legal) sel_m = s;
      acc = in_valid && !clr;
      if (clr) hist.delete();
      else if (acc) begin
        hist.push_front(in_data);
        if (hist.size() > DEPTH) void'(hist.pop_back());
      end
      ov_m = acc && (hist.size() >= TAPS * (1 << sel_m));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin : compare
    int tgt, n;
    if (chk_en) begin
      tgt = TAPS * (1 << sel_m);
      n   = hist.size();
      check("fill_count", 32'(fill_count), 32'((n < tgt) ? n : tgt));
      check("full", 32'(full), 32'(n >= tgt));
      check("stride_err", 32'(stride_err), 32'(err_m));
      check("state", 32'(dbg_state), (n == 0) ? 32'(EMPTY) : (n >= tgt) ? 32'(FULL) : 32'(FILL));
      check("out_valid", 32'(out_valid), 32'((LAT == 1) ? ov_m : ovr_m));
      for (int k = 0; k < TAPS; k++)
        check("tap", 32'(taps[k]), 32'((LAT == 1) ? comb_tap(k) : win_m[k]));
    end
  end

  // ---------------- scoreboard for directed windows ----------------
  always @(negedge clock) begin : window_sb
    logic [31:0] w;
    if (sb_en && out_valid) begin
      w = {taps[3], taps[2], taps[1], taps[0]};
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL window_extra: got 0x%08h, expected no window", w);
      end else begin
        check("window", w, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit fl);
    in_valid = v;
    in_data  = d;
    flush    = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic check_taps_zero(input string name);
    for (int k = 0; k < TAPS; k++) check(name, 32'(taps[k]), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; stride_sel = 2'd0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_fill", 32'(fill_count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_err", 32'(stride_err), 32'd0);
    check_taps_zero("rst_taps");
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // stride 1 fill: 1,2,3,4
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0);
    check("s1_ov_after_4", 32'(out_valid), 32'(LAT == 1));
    cyc(0, 0, 0);
    check("s1_ov_next", 32'(out_valid), 32'(LAT == 2));
    check("s1_window", {24'h0, taps[3]} << 24 | {24'h0, taps[2]} << 16 | {24'h0, taps[1]} << 8 | {24'h0, taps[0]},
          32'h01020304);
    check("s1_fill", 32'(fill_count), 32'd4);
    check("s1_full", 32'(full), 32'd1);

    // gaps at stride 1
    for (int i = 0; i < 16; i++) cyc((i % 2) == 0, 8'($urandom_range(0, 255)), 0);
    check("gap_fill", 32'(fill_count), 32'd4);

    // stride 2: implicit flush, then 1..9 back to back
    stride_sel = 2'd1;
    cyc(0, 0, 0);
    exp_q.push_back(32'h01030507);
    exp_q.push_back(32'h02040608);
    sb_en = 1'b1;
    for (int i = 1; i <= 9; i++) cyc(1, 8'(i), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    sb_en = 1'b0;
    check("s2_windows_seen", 32'(exp_q.size()), 32'd0);

    // flush collides with a valid sample
    check("pre_flush_full", 32'(full), 32'd1);
    cyc(1, 8'hAA, 1);
    check("flush_fill", 32'(fill_count), 32'd0);
    check("flush_full", 32'(full), 32'd0);
    check("flush_ov", 32'(out_valid), 32'd0);
    check_taps_zero("flush_taps");
    cyc(0, 0, 0);
    check_taps_zero("flush_no_aa");

    // stride change mid-fill acts as flush; stride 4 needs 16 samples
    stride_sel = 2'd0;
    cyc(0, 0, 0);
    cyc(1, 8'($urandom_range(1, 255)), 0);
    cyc(1, 8'($urandom_range(1, 255)), 0);
    check("mid_fill", 32'(fill_count), 32'd2);
    stride_sel = 2'd2;
    cyc(1, 8'($urandom_range(1, 255)), 0);
    check("chg_fill", 32'(fill_count), 32'd0);
    check("chg_full", 32'(full), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1, 8'($urandom_range(1, 255)), 0);
    check("s4_fill15", 32'(fill_count), 32'd15);
    check("s4_full15", 32'(full), 32'd0);
    cyc(1, 8'($urandom_range(1, 255)), 0);
    check("s4_fill16", 32'(fill_count), 32'd16);
    check("s4_full16", 32'(full), 32'd1);

    // reserved stride: sticky error, no flush
    stride_sel = 2'd3;
    cyc(1, 8'($urandom_range(1, 255)), 0);
    check("rsvd_err", 32'(stride_err), 32'd1);
    check("rsvd_fill", 32'(fill_count), 32'd16);
    stride_sel = 2'd2;
    cyc(0, 0, 0);
    check("err_sticky", 32'(stride_err), 32'd1);
    check("err_nofl", 32'(fill_count), 32'd16);

    // reset while full
    reset_n = 1'b0;
    cyc(0, 0, 0);
    check("mrst_fill", 32'(fill_count), 32'd0);
    check("mrst_full", 32'(full), 32'd0);
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_err", 32'(stride_err), 32'd0);
    check_taps_zero("mrst_taps");
    reset_n = 1'b1;
    stride_sel = 2'd0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) stride_sel = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 24) == 0);
    end

    cyc(0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
